reg_access_master: RTL

REG_ACCESS_MASTER -- requirements
Module: reg_access_master

---
 rtl/reg_access_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/reg_access_master.sv
// Register access master: queues write/read commands in a small FIFO and runs
// each one against a simple strobe-based target. Optional macro: READBACK_CHECK_EN.
module reg_access_master #(
  parameter int unsigned DW        = 8,
  parameter int unsigned CMD_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          tgt_write,
  output logic          tgt_read,
  output logic [DW-1:0] tgt_data_in,
  input  logic [DW-1:0] tgt_data_out
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    RSP
  } state_t;

  state_t state, state_nxt;

  logic [DW:0]   fifo_mem [CMD_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [DW:0]   head;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !rst && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = head[DW] ? RD : WR;
        end
      end
`ifdef READBACK_CHECK_EN
      WR:  state_nxt = RD;
`else
      WR:  state_nxt = RSP;
`endif
      RD:  state_nxt = CAP;
      CAP: state_nxt = RSP;
      RSP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tgt_write   = 1'b0;
    tgt_read    = 1'b0;
    tgt_data_in = '0;
    rsp_valid   = 1'b0;
    unique case (state)
      WR: begin
        tgt_write   = 1'b1;
        tgt_data_in = wdata_q;
      end
      RD:      tgt_read  = 1'b1;
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef READBACK_CHECK_EN
  logic op_q;
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop) begin
        op_q    <= head[DW];
        wdata_q <= head[DW-1:0];
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state == CAP) begin
        rdata_q <= tgt_data_out;
        err_q   <= !op_q && (tgt_data_out != wdata_q);
      end
    end
  end

  assign rsp_err = err_q;
`else
  // Response data is cleared at pop so a write responds with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (pop) begin
        wdata_q <= head[DW-1:0];
        rdata_q <= '0;
      end
      if (state == CAP) begin
        rdata_q <= tgt_data_out;
      end
    end
  end

  assign rsp_err = 1'b0;
`endif

  assign rsp_rdata = rdata_q;
  assign busy      = !fifo_empty || (state != IDLE);

endmodule
